lsu_mem_port: RTL and testbench

LSU_MEM_PORT -- requirements
Module: lsu_mem_port

---
 rtl/lsu_mem_port.sv | 186 ++++++++++++++++++
 tb/tb_lsu_mem_port.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_port.sv
// Load/store unit memory port: accepts one CPU request at a time, checks
// alignment and the RAM window, drives a fixed-latency RAM and returns a response.
module lsu_mem_port #(
    parameter logic [63:0] RAM_BASE = 64'h8000_0000,
    parameter logic [63:0] RAM_LEN  = 64'h0004_0000,
    parameter int unsigned MEM_LAT  = 1
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_wen_i,
    input  logic [63:0] req_addr_i,
    input  logic [63:0] req_wdata_i,
    input  logic [1:0]  req_wdt_i,
    input  logic        req_sext_i,

    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [63:0] resp_rdata_o,
    output logic [1:0]  resp_err_o,

    output logic [63:0] mem_raddr_o,
    output logic [63:0] mem_waddr_o,
    output logic [63:0] mem_wdata_o,
    output logic        mem_wen_o,
    output logic        mem_ren_o,
    output logic [1:0]  mem_wdt_o,
    input  logic [63:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_FAULT    = 2'b10;

    state_e      state_q, state_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [1:0]  wdt_q, wdt_d;
    logic        wen_q, wen_d;
    logic        sext_q, sext_d;
    logic [1:0]  err_q, err_d;
    logic [63:0] rdata_q, rdata_d;
    logic [2:0]  cnt_q, cnt_d;

    logic        misaligned;
    logic        fault;
    logic [3:0]  nbytes;
    logic [64:0] req_end;
    logic [64:0] ram_end;

    function automatic logic [63:0] extend(input logic [63:0] d,
                                           input logic [1:0]  wdt,
                                           input logic        sext);
        logic [63:0] r;
        r = d;
        if (sext) begin
            case (wdt)
                2'b00:   r = {{56{d[7]}},  d[7:0]};
                2'b01:   r = {{48{d[15]}}, d[15:0]};
                2'b10:   r = {{32{d[31]}}, d[31:0]};
                default: r = d;
            endcase
        end
        return r;
    endfunction

    always_comb begin
        misaligned = 1'b0;
        case (req_wdt_i)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = req_addr_i[0];
            2'b10:   misaligned = |req_addr_i[1:0];
            default: misaligned = |req_addr_i[2:0];
        endcase
    end

    // 65-bit sums so a request near the top of the address space cannot wrap into the window.
    assign nbytes  = 4'd1 << req_wdt_i;
    assign req_end = {1'b0, req_addr_i} + {61'd0, nbytes};
    assign ram_end = {1'b0, RAM_BASE} + {1'b0, RAM_LEN};
    assign fault   = (req_addr_i < RAM_BASE) || (req_end > ram_end);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wdt_d     = wdt_q;
        wen_d     = wen_q;
        sext_d    = sext_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        mem_ren_o = 1'b0;
        mem_wen_o = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    wdt_d   = req_wdt_i;
                    wen_d   = req_wen_i;
                    sext_d  = req_sext_i;
                    rdata_d = '0;
                    if (misaligned) begin
                        err_d   = ERR_MISALIGN;
                        state_d = RESP;
                    end else if (fault) begin
                        err_d   = ERR_FAULT;
                        state_d = RESP;
                    end else begin
                        err_d   = ERR_OK;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (wen_q) begin
                    mem_wen_o = 1'b1;
                    state_d   = RESP;
                end else begin
                    mem_ren_o = 1'b1;
                    cnt_d     = 3'(MEM_LAT);
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    rdata_d = extend(mem_rdata_i, wdt_q, sext_q);
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wdt_q   <= '0;
            wen_q   <= 1'b0;
            sext_q  <= 1'b0;
            err_q   <= ERR_OK;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wdt_q   <= wdt_d;
            wen_q   <= wen_d;
            sext_q  <= sext_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // Address and width come straight from the request registers so they stay stable for lane select.
    assign req_ready_o  = (state_q == IDLE);
    assign resp_valid_o = (state_q == RESP);
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;
    assign mem_raddr_o  = addr_q;
    assign mem_waddr_o  = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign mem_wdt_o    = wdt_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: a table of requests against a small byte-RAM
// model (MEM_LAT = 1) plus hand sequences for stalls, MEM_LAT = 3 and mid-flight reset.
module tb_lsu_mem_port;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_req_valid, a_req_ready, a_req_wen, a_req_sext;
    logic [63:0] a_req_addr, a_req_wdata;
    logic [1:0]  a_req_wdt;
    logic        a_resp_valid, a_resp_ready;
    logic [63:0] a_resp_rdata;
    logic [1:0]  a_resp_err;
    logic [63:0] a_mem_raddr, a_mem_waddr, a_mem_wdata, a_mem_rdata;
    logic        a_mem_wen, a_mem_ren;
    logic [1:0]  a_mem_wdt;

    logic        b_req_valid, b_req_ready, b_req_wen, b_req_sext;
    logic [63:0] b_req_addr, b_req_wdata;
    logic [1:0]  b_req_wdt;
    logic        b_resp_valid, b_resp_ready;
    logic [63:0] b_resp_rdata;
    logic [1:0]  b_resp_err;
    logic [63:0] b_mem_raddr, b_mem_waddr, b_mem_wdata, b_mem_rdata;
    logic        b_mem_wen, b_mem_ren;
    logic [1:0]  b_mem_wdt;

    lsu_mem_port #(.RAM_BASE(64'h8000_0000), .RAM_LEN(64'h0004_0000), .MEM_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_wen_i(a_req_wen),
        .req_addr_i(a_req_addr), .req_wdata_i(a_req_wdata), .req_wdt_i(a_req_wdt),
        .req_sext_i(a_req_sext),
        .resp_valid_o(a_resp_valid), .resp_ready_i(a_resp_ready),
        .resp_rdata_o(a_resp_rdata), .resp_err_o(a_resp_err),
        .mem_raddr_o(a_mem_raddr), .mem_waddr_o(a_mem_waddr), .mem_wdata_o(a_mem_wdata),
        .mem_wen_o(a_mem_wen), .mem_ren_o(a_mem_ren), .mem_wdt_o(a_mem_wdt),
        .mem_rdata_i(a_mem_rdata)
    );

    lsu_mem_port #(.RAM_BASE(64'h8000_0000), .RAM_LEN(64'h0004_0000), .MEM_LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_wen_i(b_req_wen),
        .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata), .req_wdt_i(b_req_wdt),
        .req_sext_i(b_req_sext),
        .resp_valid_o(b_resp_valid), .resp_ready_i(b_resp_ready),
        .resp_rdata_o(b_resp_rdata), .resp_err_o(b_resp_err),
        .mem_raddr_o(b_mem_raddr), .mem_waddr_o(b_mem_waddr), .mem_wdata_o(b_mem_wdata),
        .mem_wen_o(b_mem_wen), .mem_ren_o(b_mem_ren), .mem_wdt_o(b_mem_wdt),
        .mem_rdata_i(b_mem_rdata)
    );

    // Byte RAM model for dut_a, indexed by the low address byte; byte 3 preset to 0x80.
    logic [7:0] mem [0:255];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[3] <= 8'h80;
        end else if (a_mem_wen) begin
            for (int i = 0; i < 8; i++) begin
                if (i < (1 << a_mem_wdt)) mem[8'(a_mem_waddr[7:0] + 8'(i))] <= a_mem_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        logic [7:0] idx;
        a_mem_rdata = '0;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            idx = a_mem_raddr[7:0] + 8'(i);
            if (i < (1 << a_mem_wdt)) a_mem_rdata[8*i +: 8] = mem[idx];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wen;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [1:0]  wdt;
        logic        sext;
        logic [63:0] exp_rdata;
        logic [1:0]  exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs [19];

    task automatic do_req(input vec_t v);
        int lat, nren, nwen;
        logic seen;
        @(negedge clk);
        chk("req_ready idle", a_req_ready, 1);
        a_req_valid = 1'b1; a_req_wen = v.wen; a_req_addr = v.addr;
        a_req_wdata = v.wdata; a_req_wdt = v.wdt; a_req_sext = v.sext;
        @(posedge clk);
        #1 a_req_valid = 1'b0;
        lat = 0; nren = 0; nwen = 0; seen = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            if (a_mem_ren) nren++;
            if (a_mem_wen) begin
                nwen++;
                chk("mem_waddr", a_mem_waddr, v.addr);
                chk("mem_wdata", a_mem_wdata, v.wdata);
                chk("mem_wdt", 64'(a_mem_wdt), 64'(v.wdt));
            end
            if (!v.wen && v.exp_err == 2'b00 && !a_resp_valid) begin
                chk("mem_raddr", a_mem_raddr, v.addr);
                chk("mem_wdt rd", 64'(a_mem_wdt), 64'(v.wdt));
            end
            if (a_resp_valid) begin
                seen = 1'b1;
                lat = k;
            end
        end
        chk("resp_valid", a_resp_valid, 1);
        chk("latency", 64'(lat), 64'(v.exp_lat));
        chk("resp_rdata", a_resp_rdata, v.exp_rdata);
        chk("resp_err", 64'(a_resp_err), 64'(v.exp_err));
        chk("mem_ren count", 64'(nren), (!v.wen && v.exp_err == 2'b00) ? 64'd1 : 64'd0);
        chk("mem_wen count", 64'(nwen), (v.wen && v.exp_err == 2'b00) ? 64'd1 : 64'd0);
        a_resp_ready = 1'b1;
        @(posedge clk);
        #1 a_resp_ready = 1'b0;
    endtask

    initial begin
        int nvalid, nren;
        a_req_valid = 0; a_req_wen = 0; a_req_addr = '0; a_req_wdata = '0;
        a_req_wdt = 0; a_req_sext = 0; a_resp_ready = 0;
        b_req_valid = 0; b_req_wen = 0; b_req_addr = '0; b_req_wdata = '0;
        b_req_wdt = 0; b_req_sext = 0; b_resp_ready = 0;
        b_mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;

        //           wen   addr                    wdata                   wdt    sext  exp_rdata               err    lat
        vecs[0]  = '{1'b0, 64'h0000_0000_8000_0003, 64'h0,                  2'b00, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 2'b00, 3};
        vecs[1]  = '{1'b0, 64'h0000_0000_8000_0003, 64'h0,                  2'b00, 1'b0, 64'h0000_0000_0000_0080, 2'b00, 3};
        vecs[2]  = '{1'b1, 64'h0000_0000_8000_0010, 64'h1122_3344_5566_7788, 2'b11, 1'b0, 64'h0,                  2'b00, 2};
        vecs[3]  = '{1'b0, 64'h0000_0000_8000_0010, 64'h0,                  2'b11, 1'b1, 64'h1122_3344_5566_7788, 2'b00, 3};
        vecs[4]  = '{1'b0, 64'h0000_0000_8000_0014, 64'h0,                  2'b10, 1'b1, 64'h0000_0000_1122_3344, 2'b00, 3};
        vecs[5]  = '{1'b0, 64'h0000_0000_8000_0010, 64'h0,                  2'b01, 1'b1, 64'h0000_0000_0000_7788, 2'b00, 3};
        vecs[6]  = '{1'b1, 64'h0000_0000_8000_0020, 64'h0000_0000_ABCD_8001, 2'b01, 1'b0, 64'h0,                  2'b00, 2};
        vecs[7]  = '{1'b0, 64'h0000_0000_8000_0020, 64'h0,                  2'b01, 1'b1, 64'hFFFF_FFFF_FFFF_8001, 2'b00, 3};
        vecs[8]  = '{1'b0, 64'h0000_0000_8000_0020, 64'h0,                  2'b10, 1'b1, 64'h0000_0000_0000_8001, 2'b00, 3};
        vecs[9]  = '{1'b0, 64'h0000_0000_8000_0006, 64'h0,                  2'b10, 1'b1, 64'h0,                  2'b01, 1};
        vecs[10] = '{1'b1, 64'h0000_0000_7FFF_FFFF, 64'hFF,                 2'b00, 1'b0, 64'h0,                  2'b10, 1};
        // Doubleword at window end minus 4 is misaligned, and misalignment wins.
        vecs[11] = '{1'b0, 64'h0000_0000_8003_FFFC, 64'h0,                  2'b11, 1'b0, 64'h0,                  2'b01, 1};
        vecs[12] = '{1'b1, 64'h0000_0000_8003_FFFC, 64'h0000_0000_DEAD_BEEF, 2'b10, 1'b0, 64'h0,                  2'b00, 2};
        vecs[13] = '{1'b0, 64'h0000_0000_8003_FFFC, 64'h0,                  2'b10, 1'b1, 64'hFFFF_FFFF_DEAD_BEEF, 2'b00, 3};
        vecs[14] = '{1'b0, 64'h0000_0000_8004_0000, 64'h0,                  2'b10, 1'b0, 64'h0,                  2'b10, 1};
        vecs[15] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0,                  2'b11, 1'b0, 64'h0,                  2'b10, 1};
        vecs[16] = '{1'b0, 64'h0000_0000_8003_FFF8, 64'h0,                  2'b11, 1'b1, 64'hDEAD_BEEF_0000_0000, 2'b00, 3};
        vecs[17] = '{1'b0, 64'h0000_0000_8000_0000, 64'h0,                  2'b00, 1'b1, 64'h0,                  2'b00, 3};
        vecs[18] = '{1'b0, 64'h0000_0000_8000_0011, 64'h0,                  2'b01, 1'b0, 64'h0,                  2'b01, 1};

        #3;
        chk("rst req_ready", a_req_ready, 1);
        chk("rst resp_valid", a_resp_valid, 0);
        chk("rst mem_ren", a_mem_ren, 0);
        chk("rst mem_wen", a_mem_wen, 0);
        chk("rst resp_rdata", a_resp_rdata, 0);
        chk("rst resp_err", 64'(a_resp_err), 0);
        chk("rst mem_raddr", a_mem_raddr, 0);
        chk("rst mem_wdata", a_mem_wdata, 0);
        #9 rst_n = 1'b1;

        for (int i = 0; i < 19; i++) do_req(vecs[i]);

        // Response stall: five cycles of resp_ready low, then a request queued on the handshake cycle.
        @(negedge clk);
        a_req_valid = 1'b1; a_req_wen = 1'b0; a_req_addr = 64'h8000_0003;
        a_req_wdt = 2'b00; a_req_sext = 1'b1;
        @(posedge clk);
        #1 a_req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("stall resp_valid first", a_resp_valid, 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall resp_valid", a_resp_valid, 1);
            chk("stall resp_rdata", a_resp_rdata, 64'hFFFF_FFFF_FFFF_FF80);
            chk("stall resp_err", 64'(a_resp_err), 0);
            chk("stall req_ready", a_req_ready, 0);
        end
        a_resp_ready = 1'b1;
        a_req_valid = 1'b1; a_req_addr = 64'h8000_0001; a_req_wdt = 2'b01; a_req_sext = 1'b0;
        @(posedge clk);
        #1 a_resp_ready = 1'b0;
        @(negedge clk);
        chk("post hs req_ready", a_req_ready, 1);
        chk("post hs resp_valid", a_resp_valid, 0);
        @(posedge clk);
        #1 a_req_valid = 1'b0;
        @(negedge clk);
        chk("next resp_valid", a_resp_valid, 1);
        chk("next resp_err", 64'(a_resp_err), 64'(2'b01));
        a_resp_ready = 1'b1;
        @(posedge clk);
        #1 a_resp_ready = 1'b0;

        // MEM_LAT = 3: read data is only valid during the fourth cycle after acceptance.
        @(negedge clk);
        b_req_valid = 1'b1; b_req_wen = 1'b0; b_req_addr = 64'h8000_0040;
        b_req_wdt = 2'b01; b_req_sext = 1'b0;
        @(posedge clk);
        #1 b_req_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("b mem_ren", b_mem_ren, (k == 1) ? 64'd1 : 64'd0);
            chk("b resp_valid", b_resp_valid, (k == 5) ? 64'd1 : 64'd0);
            if (k < 5) chk("b mem_raddr", b_mem_raddr, 64'h8000_0040);
            if (k == 3) begin
                @(posedge clk);
                #1 b_mem_rdata = 64'h0000_0000_0000_8001;
            end
            if (k == 4) begin
                @(posedge clk);
                #1 b_mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
            end
        end
        chk("b resp_rdata", b_resp_rdata, 64'h0000_0000_0000_8001);
        chk("b resp_err", 64'(b_resp_err), 0);
        b_resp_ready = 1'b1;
        @(posedge clk);
        #1 b_resp_ready = 1'b0;

        // Reset while the load waits in WAIT.
        @(negedge clk);
        b_req_valid = 1'b1; b_req_addr = 64'h8000_0048;
        @(posedge clk);
        #1 b_req_valid = 1'b0;
        @(negedge clk);
        chk("b issue mem_ren", b_mem_ren, 1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async rst mem_ren", b_mem_ren, 0);
        chk("async rst resp_valid", b_resp_valid, 0);
        chk("async rst req_ready", b_req_ready, 1);
        chk("async rst mem_raddr", b_mem_raddr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        nvalid = 0; nren = 0;
        repeat (10) begin
            @(negedge clk);
            if (b_resp_valid) nvalid++;
            if (b_mem_ren) nren++;
        end
        chk("post rst resp count", 64'(nvalid), 0);
        chk("post rst ren count", 64'(nren), 0);
        chk("post rst req_ready", b_req_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
